// File: rtl/wb_ram_slave.sv
// Wishbone classic slave: word-organised RAM with byte-lane writes, a fixed
// wait-state count and error termination for accesses outside its window.
module wb_ram_slave #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int          LP_IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LP_BYTES  = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  LP_CNT_LD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TERM = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                w_enter_term;

  logic                r_we;
  logic [3:0]          r_sel;
  logic [31:0]         r_dat;
  logic [LP_IDX_W-1:0] r_idx;
  logic                r_hit;

  logic                r_ack;
  logic                r_err;
  logic [31:0]         r_dat_o;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic [31:0]         w_off;
  logic                w_in_hit;
  logic [LP_IDX_W-1:0] w_in_idx;
  logic                w_idle;
  logic                w_op_we;
  logic [3:0]          w_op_sel;
  logic [31:0]         w_op_dat;
  logic [LP_IDX_W-1:0] w_op_idx;
  logic                w_op_hit;
  logic                w_wr;

  assign w_off    = wb_adr_i - BASE_ADDR;
  assign w_in_hit = ({1'b0, w_off} < LP_BYTES);
  assign w_in_idx = w_off[LP_IDX_W+1:2];
  assign w_idle   = (r_state == S_IDLE);

  // With no wait states the accepting edge also terminates, so use live inputs then.
  assign w_op_we  = w_idle ? wb_we_i  : r_we;
  assign w_op_sel = w_idle ? wb_sel_i : r_sel;
  assign w_op_dat = w_idle ? wb_dat_i : r_dat;
  assign w_op_idx = w_idle ? w_in_idx : r_idx;
  assign w_op_hit = w_idle ? w_in_hit : r_hit;
  assign w_wr     = w_enter_term & w_op_hit & w_op_we & ~rst_i;

  // State and wait counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and termination decode
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_term = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt  = S_TERM;
            w_enter_term = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LP_CNT_LD;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt  = S_TERM;
          w_enter_term = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_TERM: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture at acceptance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we  <= 1'b0;
      r_sel <= 4'd0;
      r_dat <= 32'd0;
      r_idx <= '0;
      r_hit <= 1'b0;
    end else if (w_idle && wb_cyc_i && wb_stb_i) begin
      r_we  <= wb_we_i;
      r_sel <= wb_sel_i;
      r_dat <= wb_dat_i;
      r_idx <= w_in_idx;
      r_hit <= w_in_hit;
    end
  end

  // Registered termination and read data; dat_o holds between reads/errors
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= 32'd0;
    end else begin
      r_ack <= w_enter_term & w_op_hit;
      r_err <= w_enter_term & ~w_op_hit;
      if (w_enter_term && !w_op_hit) begin
        r_dat_o <= 32'd0;
      end else if (w_enter_term && !w_op_we) begin
        r_dat_o <= r_mem[w_op_idx];
      end
    end
  end

  // RAM byte-lane write port; contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (w_wr && w_op_sel[b]) begin
        r_mem[w_op_idx][8*b +: 8] <= w_op_dat[8*b +: 8];
      end
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_dat_o = r_dat_o;

endmodule

// File: doc/wb_ram_slave.md
Name: wb_ram_slave

Overview:
Wishbone classic (B3, non-pipelined) slave that terminates the bus cycles driven by the core's Wishbone master adapter. It contains a word-organised RAM with byte-lane writes and a programmable wait-state count. Out-of-window accesses get an error termination. It sits on the far end of the core's Wishbone port and serves as the data/instruction memory in the SoC.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit RAM words (power of two, ≥2)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to DEPTH_WORDS*4)
WAIT_STATES, 1, extra cycles inserted between request acceptance and termination (0..15)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
wb_cyc_i  in  1  bus cycle in progress
wb_stb_i  in  1  strobe, transfer valid
wb_we_i  in  1  1=write, 0=read
wb_adr_i  in  32  byte address
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte lane enables, bit n = bits [8n+7:8n]
wb_dat_o  out  32  read data
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination (address outside window)

Behaviour:
- Reset (async assert, synchronous-safe deassert assumed from system): state=IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, wait counter=0. RAM contents are not reset.
- Request accepted when state=IDLE and wb_cyc_i&wb_stb_i=1 at a rising edge. At acceptance:
  - latch we, sel, dat_i, word index = (wb_adr_i-BASE_ADDR)>>2, and hit = (wb_adr_i-BASE_ADDR) < DEPTH_WORDS*4 (unsigned);
  - wb_adr_i[1:0] is ignored.
- FSM IDLE -> WAIT -> TERM -> IDLE.
  - If WAIT_STATES=0, IDLE goes directly to TERM.
  - WAIT loads counter=WAIT_STATES-1 on entry, decrements each cycle, and exits to TERM when counter=0.
- Latency: request accepted at edge T gives termination (ack or err) high during cycle T+1+WAIT_STATES. The termination signal is high for exactly one cycle.
- Termination is registered. The edge entering TERM does the following:
  - hit & we: write RAM bytes where latched sel=1; other bytes are unchanged; sel=0000 writes nothing but still acks. wb_ack_o=1.
  - hit & !we: wb_dat_o <= RAM[index]. wb_ack_o=1.
  - !hit: wb_err_o=1, wb_dat_o <= 0, no RAM write.
- wb_ack_o and wb_err_o are never high together.
- wb_dat_o holds its value until the next read termination or error.
- TERM -> IDLE unconditionally. Back-to-back transfers therefore cost ≥2 cycles each. The master keeping stb high in the IDLE cycle after a termination is a new request.
- Abort: wb_cyc_i=0 at any edge while in WAIT → go to IDLE. No RAM write, no ack/err, wb_dat_o unchanged.
  - A cyc drop during TERM has no effect; the write is already committed.
- wb_stb_i deasserting with cyc held during WAIT is ignored; the latched transfer completes.
- Inputs are not sampled outside IDLE, except cyc for abort.
- Reset mid-transfer: outputs clear immediately, FSM goes to IDLE, and a pending write is dropped.
- Index width = log2(DEPTH_WORDS); the upper address bits only participate in the hit check.

Test Plan:
- WAIT_STATES=1, write adr=0x10 dat=0xDEADBEEF sel=1111 at edge T -> ack high only in cycle T+2, err=0. Read 0x10 -> ack with wb_dat_o=0xDEADBEEF.
- Byte lanes: word 0x20=0x11223344, then write dat=0xAABBCCDD sel=0101 -> read returns 0x11BB33DD. A sel=0000 write is acked and leaves the word unchanged.
- Out of range, DEPTH_WORDS=1024, BASE=0: read adr=0x1000 -> err for one cycle, ack=0, wb_dat_o=0. Write to 0x1000 does not alias: word 0 is unchanged.
- Abort: WAIT_STATES=3, write to 0x40 accepted, cyc dropped 1 cycle later -> no ack/err, and a subsequent read of 0x40 returns the old value.
- WAIT_STATES=0, master holds cyc/stb across consecutive reads of 0x0 and 0x4 -> acks in alternating cycles (ack, idle, ack), each with the correct data.
- Assert rst_i during WAIT of a write -> ack/err/dat_o=0 immediately, write not performed, next transfer behaves normally.
